// File: rtl/vga_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_pkg : default 640x480@60 timing constants and timing helpers           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Sync window is [sync_start, sync_end) in counter units.
  function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                           input int unsigned sync);
    return active + fp + sync;
  endfunction

  localparam int unsigned DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

`default_nettype wire

// File: rtl/sync_delay.sv
// +----------------------------------------------------------------------------+
// | sync_delay : enable-qualified delay line, DEPTH 0 is a plain wire          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = clk ^ rst_n ^ en;
      assign dout      = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) stage_d[i] = stage_q[i];
        if (en) begin
          stage_d[0] = din;
          for (int i = 1; i < int'(DEPTH); i++) stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
        end else begin
          for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= stage_d[i];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_param.sv
// +----------------------------------------------------------------------------+
// | vga_timing_param : parametrised raster counter with sync / active decode   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_param
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned SYNC_DLY = 1,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               valid,
  output logic               de,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if ((longint'(H_TOTAL) - 1 > (longint'(1) << COORD_W) - 1) ||
        (longint'(V_TOTAL) - 1 > (longint'(1) << COORD_W) - 1) ||
        (SYNC_DLY > 4) || (COORD_W == 0) || (FRAME_W == 0) ||
        (H_ACTIVE == 0) || (H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_ACTIVE == 0) || (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_bad_cfg
      $error("vga_timing_param: illegal timing/width parameters");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] H_EOL    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d   = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          row_d = row_q + COORD_W'(1);
        end
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      frame_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

  // Gating with rst_n keeps the flags quiet during reset while letting
  // coordinate (0,0) be reported as active the moment reset is released.
  logic active, hs_raw, vs_raw;
  assign active = (col_q < H_ACT) && (row_q < V_ACT);
  assign hs_raw = ((col_q >= HS_START) && (col_q < HS_END)) ? H_POL : ~H_POL;
  assign vs_raw = ((row_q >= VS_START) && (row_q < VS_END)) ? V_POL : ~V_POL;

  assign valid     = rst_n & active;
  assign sof       = rst_n & pix_en & (col_q == '0) & (row_q == '0);
  assign eol       = rst_n & pix_en & (col_q == H_EOL) & (row_q < V_ACT);
  assign row       = row_q;
  assign col       = col_q;
  assign frame_cnt = frame_q;

  logic [2:0] dly_out;

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DLY),
    .RST_VAL ({~H_POL, ~V_POL, 1'b0})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .din   ({hs_raw, vs_raw, valid}),
    .dout  (dly_out)
  );

  assign HSYNC = dly_out[2];
  assign VSYNC = dly_out[1];
  assign de    = dly_out[0];

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_param.sv
// Scoreboard bench: three configurations share one stimulus stream; a raster
// model driven by the advance count since reset predicts every cycle's outputs.
`default_nettype none

module tb_vga_timing_param;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        valid;
    logic        de;
    logic        sof;
    logic        eol;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] frame;
  } out_t;

  typedef struct {
    longint ha, hf, hs, hb, va, vf, vs, vb;
    bit     hp, vp;
    longint d, fw;
  } cfg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default 640x480 timing
  logic       hs0, vs0, va0, de0, sof0, eol0;
  logic [9:0] row0, col0;
  logic [7:0] fr0;
  vga_timing_param dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .HSYNC(hs0), .VSYNC(vs0), .valid(va0),
    .de(de0), .row(row0), .col(col0), .sof(sof0), .eol(eol0), .frame_cnt(fr0)
  );

  // DUT 1: tiny raster, active-high syncs, 3-stage delay, 2-bit frame counter
  logic       hs1, vs1, va1, de1, sof1, eol1;
  logic [3:0] row1, col1;
  logic [1:0] fr1;
  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .SYNC_DLY(3), .COORD_W(4), .FRAME_W(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .HSYNC(hs1), .VSYNC(vs1), .valid(va1),
    .de(de1), .row(row1), .col(col1), .sof(sof1), .eol(eol1), .frame_cnt(fr1)
  );

  // DUT 2: tiny raster, no delay stage
  logic       hs2, vs2, va2, de2, sof2, eol2;
  logic [3:0] row2, col2;
  logic [2:0] fr2;
  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(0), .COORD_W(4), .FRAME_W(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .HSYNC(hs2), .VSYNC(vs2), .valid(va2),
    .de(de2), .row(row2), .col(col2), .sof(sof2), .eol(eol2), .frame_cnt(fr2)
  );

  cfg_t cfg [3];
  out_t q0[$], q1[$], q2[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  // n = pixel advances since the last reset edge; everything follows from it.
  function automatic out_t model(cfg_t c, longint n, bit rst, bit pe);
    out_t   o;
    longint ht, vt, cl, rw, m, mc, mr;
    bit     hs_on, vs_on;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    cl = n % ht;
    rw = (n / ht) % vt;
    o.col   = 16'(cl);
    o.row   = 16'(rw);
    o.frame = 16'((n / (ht * vt)) % (longint'(1) << c.fw));
    o.valid = rst && (cl < c.ha) && (rw < c.va);
    o.sof   = rst && pe && (cl == 0) && (rw == 0);
    o.eol   = rst && pe && (cl == c.ha - 1) && (rw < c.va);
    if (n < c.d) begin
      o.hs = ~c.hp;
      o.vs = ~c.vp;
      o.de = 1'b0;
    end else begin
      m     = n - c.d;
      mc    = m % ht;
      mr    = (m / ht) % vt;
      hs_on = (mc >= c.ha + c.hf) && (mc < c.ha + c.hf + c.hs);
      vs_on = (mr >= c.va + c.vf) && (mr < c.va + c.vf + c.vs);
      o.hs  = hs_on ? c.hp : ~c.hp;
      o.vs  = vs_on ? c.vp : ~c.vp;
      o.de  = (c.d == 0) ? o.valid : ((mc < c.ha) && (mr < c.va));
    end
    return o;
  endfunction

  task automatic compare(input string name, input int cyc, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual hs=%b vs=%b valid=%b de=%b sof=%b eol=%b row=%0d col=%0d frame=%0d required hs=%b vs=%b valid=%b de=%b sof=%b eol=%b row=%0d col=%0d frame=%0d",
               name, cyc, act.hs, act.vs, act.valid, act.de, act.sof, act.eol, act.row, act.col, act.frame,
               exp.hs, exp.vs, exp.valid, exp.de, exp.sof, exp.eol, exp.row, exp.col, exp.frame);
    end
  endtask

  // Stimulus: drive inputs just after the falling edge, predict this cycle.
  initial begin
    longint n = 0;
    bit     have_reset = 1'b0;
    int     rst_left = 3;
    cfg[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:1'b0, vp:1'b0, d:1, fw:8};
    cfg[1] = '{ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1, hp:1'b1, vp:1'b1, d:3, fw:2};
    cfg[2] = '{ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1, hp:1'b0, vp:1'b0, d:0, fw:3};
    for (int cyc = 0; cyc < 22000; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 12000) rst_left = 3;
      if (cyc > 12000 && rst_left == 0 && $urandom_range(0, 2999) == 0) rst_left = 1 + $urandom_range(0, 2);
      rst_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      if (cyc < 6000)       pix_en = 1'b1;
      else if (cyc < 10000) pix_en = (cyc % 2 == 0);
      else                  pix_en = ($urandom_range(0, 3) != 0);
      if (cyc < 3) pix_en = $urandom_range(0, 1);
      if (have_reset) begin
        q0.push_back(model(cfg[0], n, rst_n, pix_en));
        q1.push_back(model(cfg[1], n, rst_n, pix_en));
        q2.push_back(model(cfg[2], n, rst_n, pix_en));
      end
      if (!rst_n) begin
        n = 0;
        have_reset = 1'b1;
      end else if (pix_en) begin
        n++;
      end
    end
    @(negedge clk);
    stim_done = 1'b1;
  end

  // Monitor: pops the prediction for the cycle being presented.
  initial begin
    int   cyc = 0;
    out_t e;
    while (!stim_done) begin
      @(negedge clk);
      #3;
      while (q0.size() > 0) begin
        e = q0.pop_front();
        compare("dut0_default", cyc, {hs0, vs0, va0, de0, sof0, eol0, 16'(row0), 16'(col0), 16'(fr0)}, e);
      end
      while (q1.size() > 0) begin
        e = q1.pop_front();
        compare("dut1_pol_dly3", cyc, {hs1, vs1, va1, de1, sof1, eol1, 16'(row1), 16'(col1), 16'(fr1)}, e);
      end
      while (q2.size() > 0) begin
        e = q2.pop_front();
        compare("dut2_dly0", cyc, {hs2, vs2, va2, de2, sof2, eol2, 16'(row2), 16'(col2), 16'(fr2)}, e);
      end
      cyc++;
    end
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL too_few_checks actual=%0d required>=12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
